// File: rtl/result_bcd_formatter.sv
// result_bcd_formatter: sequential double-dabble conversion of quotient/remainder to BCD with blank masks; ports clk, rst, start, quotient_in, remainder_in -> busy, done, q_bcd, r_bcd, q_blank, r_blank
module result_bcd_formatter #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      quotient_in,
  input  logic [WIDTH-1:0]      remainder_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   q_bcd,
  output logic [4*DIGITS-1:0]   r_bcd,
  output logic [DIGITS-1:0]     q_blank,
  output logic [DIGITS-1:0]     r_blank
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam int BW = 4 * DIGITS;
  typedef enum logic [1:0] {IDLE, CONV_Q, CONV_R, DONE} state_t;
  state_t            state_q, state_d;
  logic [CW-1:0]     count_q, count_d;
  logic [WIDTH-1:0]  qs_q, qs_d, rs_q, rs_d;
  logic [BW-1:0]     scr_q, scr_d, qres_q, qres_d;
  logic [BW-1:0]     q_bcd_q, q_bcd_d, r_bcd_q, r_bcd_d;
  logic [DIGITS-1:0] q_blank_q, q_blank_d, r_blank_q, r_blank_d;
  logic [BW-1:0]     corr, shifted;
  logic [WIDTH-1:0]  op;
  logic              last, load;
  function automatic logic [DIGITS-1:0] blank(input logic [BW-1:0] b);
    logic [DIGITS-1:0] m;
    logic z;
    m = '0;
    z = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      z = z & (b[4*i+:4] == 4'd0);
      m[i] = z;
    end
    return m;
  endfunction
  always_comb begin
    corr = '0;
    for (int i = 0; i < DIGITS; i++)
      corr[4*i+:4] = scr_q[4*i+:4] >= 4'd5 ? scr_q[4*i+:4] + 4'd3 : scr_q[4*i+:4];
    op        = state_q == CONV_Q ? qs_q : rs_q;
    shifted   = {corr[BW-2:0], op[WIDTH-1]};
    last      = count_q == CW'(WIDTH - 1);
    load      = (state_q == IDLE || state_q == DONE) && start;
    state_d   = state_q;
    count_d   = count_q;
    qs_d      = qs_q;
    rs_d      = rs_q;
    scr_d     = scr_q;
    qres_d    = qres_q;
    q_bcd_d   = q_bcd_q;
    r_bcd_d   = r_bcd_q;
    q_blank_d = q_blank_q;
    r_blank_d = r_blank_q;
    if (load) begin
      qs_d    = quotient_in;
      rs_d    = remainder_in;
      scr_d   = '0;
      count_d = '0;
      state_d = CONV_Q;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end else if (state_q == CONV_Q) begin
      qs_d    = qs_q << 1;
      scr_d   = last ? '0 : shifted;
      count_d = last ? '0 : count_q + CW'(1);
      qres_d  = last ? shifted : qres_q;
      state_d = last ? CONV_R : CONV_Q;
    end else if (state_q == CONV_R) begin
      rs_d    = rs_q << 1;
      scr_d   = shifted;
      count_d = last ? '0 : count_q + CW'(1);
      state_d = last ? DONE : CONV_R;
      if (last) begin
        q_bcd_d   = qres_q;
        r_bcd_d   = shifted;
        q_blank_d = blank(qres_q);
        r_blank_d = blank(shifted);
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      count_q   <= '0;
      qs_q      <= '0;
      rs_q      <= '0;
      scr_q     <= '0;
      qres_q    <= '0;
      q_bcd_q   <= '0;
      r_bcd_q   <= '0;
      q_blank_q <= '0;
      r_blank_q <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      qs_q      <= qs_d;
      rs_q      <= rs_d;
      scr_q     <= scr_d;
      qres_q    <= qres_d;
      q_bcd_q   <= q_bcd_d;
      r_bcd_q   <= r_bcd_d;
      q_blank_q <= q_blank_d;
      r_blank_q <= r_blank_d;
    end
  end
  assign busy    = state_q == CONV_Q || state_q == CONV_R;
  assign done    = state_q == DONE;
  assign q_bcd   = q_bcd_q;
  assign r_bcd   = r_bcd_q;
  assign q_blank = q_blank_q;
  assign r_blank = r_blank_q;
endmodule
